// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary encoder front end.
// Contents: quadrature Gray states, step direction encodings, default
// debounce length, and a helper that maps an AB state to its position
// along the clockwise sequence.
package rotary_pkg;

  // AB levels for the four quadrature states. The clockwise order is
  // 11 -> 01 -> 00 -> 10 -> 11.
  typedef enum logic [1:0] {
    QS_11 = 2'b11,
    QS_01 = 2'b01,
    QS_00 = 2'b00,
    QS_10 = 2'b10
  } quad_state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // 1 ms at 50 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;

  // Position along the clockwise cycle. The difference of two positions,
  // taken modulo 4, is 1 for a CW move, 3 for CCW and 2 for a double change.
  function automatic logic [1:0] quad_pos(input logic [1:0] ab);
    case (ab)
      QS_11:   quad_pos = 2'd0;
      QS_01:   quad_pos = 2'd1;
      QS_00:   quad_pos = 2'd2;
      default: quad_pos = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/rotary_debounce.sv
// Two-flop synchroniser followed by a stability filter for one
// asynchronous, idle-high input.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset (filter and synchroniser reset to 1)
//   pin    raw asynchronous input
//   level  filtered level; follows pin once it has held a new value for
//          DEBOUNCE_CYCLES consecutive synchronised samples
module rotary_debounce
  import rotary_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] stable_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      stable_cnt <= '0;
      level      <= 1'b1;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      // Counts only while the synchronised value disagrees with the filtered
      // one; any return to agreement restarts the wait.
      if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        stable_cnt <= '0;
        level      <= sync2;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rotary_quad_counter.sv
// Rotary encoder front end: debounces the A/B channels and push switch,
// decodes quadrature transitions into detent steps, and keeps an up/down
// position count for the seven-segment display path.
// Ports:
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset
//   rot_a, rot_b   encoder channels, asynchronous, idle high
//   rot_sw_n       push switch, asynchronous, active low
//   count_export   position count
//   step_pulse     one-cycle strobe per detent step
//   step_dir       direction of the last step (1 = up/CW)
//   clear_pulse    one-cycle strobe when the switch clears the count
//   quad_err       sticky illegal-transition flag
module rotary_quad_counter
  import rotary_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned COUNT_WIDTH      = 8,
  parameter int unsigned STEPS_PER_DETENT = 4,
  parameter bit          WRAP             = 1'b1
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic                   rot_a,
  input  logic                   rot_b,
  input  logic                   rot_sw_n,
  output logic [COUNT_WIDTH-1:0] count_export,
  output logic                   step_pulse,
  output logic                   step_dir,
  output logic                   clear_pulse,
  output logic                   quad_err
);

  localparam logic signed [3:0] ACC_MAX = $signed(4'(STEPS_PER_DETENT));
  localparam logic signed [3:0] ACC_MIN = -ACC_MAX;

  logic filt_a;
  logic filt_b;
  logic filt_sw;

  rotary_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk_clk), .rst_n(reset_reset_n), .pin(rot_a), .level(filt_a)
  );
  rotary_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk_clk), .rst_n(reset_reset_n), .pin(rot_b), .level(filt_b)
  );
  rotary_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sw (
    .clk(clk_clk), .rst_n(reset_reset_n), .pin(rot_sw_n), .level(filt_sw)
  );

  logic [1:0]             prev_ab;
  logic                   sw_prev;
  logic signed [3:0]      acc;

  logic [1:0]             cur_ab;
  logic [1:0]             move;
  logic                   clear_now;
  logic signed [3:0]      delta;
  logic signed [3:0]      acc_sum;
  logic signed [3:0]      acc_next;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   step_next;
  logic                   dir_next;
  logic                   err_next;

  always_comb begin
    cur_ab     = {filt_a, filt_b};
    move       = quad_pos(cur_ab) - quad_pos(prev_ab);
    clear_now  = sw_prev & ~filt_sw;
    delta      = '0;
    acc_next   = acc;
    count_next = count_export;
    step_next  = 1'b0;
    dir_next   = step_dir;
    err_next   = quad_err;

    case (move)
      2'd1:    delta = 4'sd1;
      2'd3:    delta = -4'sd1;
      2'd2:    err_next = 1'b1;
      default: ;
    endcase

    acc_sum = acc + delta;
    if (acc_sum == ACC_MAX) begin
      acc_next  = '0;
      step_next = 1'b1;
      dir_next  = DIR_UP;
      if (WRAP || count_export != '1) count_next = count_export + COUNT_WIDTH'(1);
    end else if (acc_sum == ACC_MIN) begin
      acc_next  = '0;
      step_next = 1'b1;
      dir_next  = DIR_DN;
      if (WRAP || count_export != '0) count_next = count_export - COUNT_WIDTH'(1);
    end else begin
      acc_next = acc_sum;
    end

    // A clear on the same cycle as a step swallows the step entirely.
    if (clear_now) begin
      acc_next   = '0;
      count_next = '0;
      step_next  = 1'b0;
      dir_next   = step_dir;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      prev_ab      <= QS_11;
      sw_prev      <= 1'b1;
      acc          <= '0;
      count_export <= '0;
      step_pulse   <= 1'b0;
      step_dir     <= 1'b0;
      clear_pulse  <= 1'b0;
      quad_err     <= 1'b0;
    end else begin
      prev_ab      <= cur_ab;
      sw_prev      <= filt_sw;
      acc          <= acc_next;
      count_export <= count_next;
      step_pulse   <= step_next;
      step_dir     <= dir_next;
      clear_pulse  <= clear_now;
      quad_err     <= err_next;
    end
  end

endmodule
